// File: rtl/amp_pkg.sv
// rtl/amp_pkg.sv - shared result-word layout for the amplifier result path
package amp_pkg;

    localparam int NO_W          = 8;
    localparam int RES_W         = 24;
    localparam int RD_DATA_WIDTH = NO_W + RES_W;

    // One amplifier result beat: sequence number in the top byte, value below.
    typedef struct packed {
        logic [NO_W-1:0]  no;
        logic [RES_W-1:0] res;
    } amp_result_t;

    localparam int RESULT_W = $bits(amp_result_t);

    // Extract the sequence number from a result beat.
    function automatic logic [NO_W-1:0] result_no(input amp_result_t r);
        return r.no;
    endfunction

    // Sequence number expected after n; 255 wraps to 0.
    function automatic logic [NO_W-1:0] next_no(input logic [NO_W-1:0] n);
        return n + NO_W'(1);
    endfunction

endpackage

// File: rtl/amp_sync_fifo.sv
// rtl/amp_sync_fifo.sv - show-ahead synchronous FIFO storage and pointers
module amp_sync_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DATA_W-1:0]        data_i,
    output logic [DATA_W-1:0]        data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    // Pointers wrap naturally since DEPTH is a power of two; push/pop arrive pre-qualified.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards whatever was stored.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk_i) begin
        if (push_i && !rst_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/amp_result_buffer.sv
// rtl/amp_result_buffer.sv - amplifier result FIFO with sticky overflow and optional sequence checker (AMP_RESULT_SEQ_CHECK_EN)
`ifndef RD_DATA_WIDTH
`define RD_DATA_WIDTH 32
`endif

module amp_result_buffer
    import amp_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = `RD_DATA_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_val_i,
    input  logic [DATA_W-1:0]        in_data_i,
    output logic                     out_val_o,
    input  logic                     out_rdy_i,
    output logic [DATA_W-1:0]        out_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     ovf_o,
    output logic                     seq_err_o,
    input  logic                     clr_i
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] count_s;
    logic          empty_s;
    logic          full_s;
    logic          pop_s;
    logic          push_s;
    logic          ovf_set_s;
    logic          ovf_q, ovf_d;

    assign empty_s   = (count_s == '0);
    assign full_s    = (count_s == CW'(DEPTH));
    assign pop_s     = !empty_s && out_rdy_i;
    // A pop on the same edge frees a slot, so a full FIFO still accepts.
    assign push_s    = in_val_i && (!full_s || pop_s);
    assign ovf_set_s = in_val_i && !push_s;

    amp_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .data_i  (in_data_i),
        .data_o  (out_data_o),
        .count_o (count_s)
    );

    // Overflow flag: a drop on this edge wins over a clear.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (clr_i) begin
            ovf_d = 1'b0;
        end
    end

    // Sticky overflow register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

`ifdef AMP_RESULT_SEQ_CHECK_EN
    logic            armed_q, armed_d;
    logic [NO_W-1:0] exp_q, exp_d;
    logic            seq_err_q, seq_err_d;
    logic [NO_W-1:0] no_s;
    logic            gap_s;

    assign no_s  = result_no(in_data_i[RESULT_W-1:0]);
    // Every beat is checked, including ones dropped by a full FIFO.
    assign gap_s = in_val_i && armed_q && (no_s != exp_q);

    // Checker next state: any beat re-arms and reloads; a lone clear disarms.
    always_comb begin
        armed_d   = armed_q;
        exp_d     = exp_q;
        seq_err_d = seq_err_q;
        if (in_val_i) begin
            armed_d = 1'b1;
            exp_d   = next_no(no_s);
        end else if (clr_i) begin
            armed_d = 1'b0;
        end
        if (gap_s) begin
            seq_err_d = 1'b1;
        end else if (clr_i) begin
            seq_err_d = 1'b0;
        end
    end

    // Sequence checker registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            armed_q   <= 1'b0;
            exp_q     <= '0;
            seq_err_q <= 1'b0;
        end else begin
            armed_q   <= armed_d;
            exp_q     <= exp_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign seq_err_o = seq_err_q;
`else
    assign seq_err_o = 1'b0;
`endif

    assign count_o   = count_s;
    assign empty_o   = empty_s;
    assign full_o    = full_s;
    assign out_val_o = !empty_s;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_amp_result_buffer.sv
// tb/tb_amp_result_buffer.sv - self-checking bench for amp_result_buffer
module tb_amp_result_buffer;
    import amp_pkg::*;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 32;
    localparam int CW     = $clog2(DEPTH) + 1;
`ifdef AMP_RESULT_SEQ_CHECK_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              in_val_i = 1'b0;
    logic [DATA_W-1:0] in_data_i = '0;
    logic              out_rdy_i = 1'b0;
    logic              clr_i = 1'b0;
    logic              out_val_o;
    logic [DATA_W-1:0] out_data_o;
    logic [CW-1:0]     count_o;
    logic              full_o;
    logic              empty_o;
    logic              ovf_o;
    logic              seq_err_o;

    amp_result_buffer #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .in_val_i   (in_val_i),
        .in_data_i  (in_data_i),
        .out_val_o  (out_val_o),
        .out_rdy_i  (out_rdy_i),
        .out_data_o (out_data_o),
        .count_o    (count_o),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .ovf_o      (ovf_o),
        .seq_err_o  (seq_err_o),
        .clr_i      (clr_i)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: a queue of stored words plus flag/checker state.
    logic [DATA_W-1:0] m_q [$];
    bit                m_ovf   = 1'b0;
    bit                m_err   = 1'b0;
    bit                m_armed = 1'b0;
    logic [7:0]        m_exp   = 8'd0;

    function automatic logic [31:0] mk(input int no, input int res);
        logic [31:0] w;
        w = {no[7:0], res[23:0]};
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_edge();
        bit popd, pushd, gap;
        if (rst_i) begin
            m_q.delete();
            m_ovf   = 1'b0;
            m_err   = 1'b0;
            m_armed = 1'b0;
        end else begin
            popd  = (m_q.size() > 0) && out_rdy_i;
            pushd = in_val_i && ((m_q.size() < DEPTH) || popd);
            if (popd) void'(m_q.pop_front());
            if (pushd) m_q.push_back(in_data_i);
            if (in_val_i && !pushd) m_ovf = 1'b1;
            else if (clr_i) m_ovf = 1'b0;
            if (SEQ_EN) begin
                gap = in_val_i && m_armed && (in_data_i[31:24] != m_exp);
                if (gap) m_err = 1'b1;
                else if (clr_i) m_err = 1'b0;
                if (in_val_i) begin
                    m_armed = 1'b1;
                    m_exp   = in_data_i[31:24] + 8'd1;
                end else if (clr_i) begin
                    m_armed = 1'b0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] head;
        head = (m_q.size() > 0) ? m_q[0] : 32'd0;
        check({tag, ".count"},   32'(count_o),   32'(m_q.size()));
        check({tag, ".empty"},   32'(empty_o),   32'(m_q.size() == 0));
        check({tag, ".full"},    32'(full_o),    32'(m_q.size() == DEPTH));
        check({tag, ".val"},     32'(out_val_o), 32'(m_q.size() != 0));
        check({tag, ".data"},    out_data_o,     head);
        check({tag, ".ovf"},     32'(ovf_o),     32'(m_ovf));
        check({tag, ".seq_err"}, 32'(seq_err_o), 32'(m_err));
    endtask

    task automatic step(input string tag, input bit r, input bit v, input logic [31:0] d,
                        input bit rdy, input bit c);
        rst_i     = r;
        in_val_i  = v;
        in_data_i = d;
        out_rdy_i = rdy;
        clr_i     = c;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        int seq_no;
        // Reset held for two cycles.
        step("rst0", 1, 0, 0, 0, 0);
        step("rst1", 1, 0, 0, 0, 0);
        check("rst.empty", 32'(empty_o), 32'd1);
        check("rst.count", 32'(count_o), 32'd0);
        check("rst.ovf",   32'(ovf_o),   32'd0);

        // Ordered drain.
        step("push1", 0, 1, mk(1, 125), 0, 0);
        check("lat1.val", 32'(out_val_o), 32'd1);
        step("push2", 0, 1, mk(2, 250), 0, 0);
        step("push3", 0, 1, mk(3, 375), 0, 0);
        check("drain.cnt3", 32'(count_o), 32'd3);
        check("drain.head1", out_data_o, mk(1, 125));
        step("pop1", 0, 0, 0, 1, 0);
        check("drain.head2", out_data_o, mk(2, 250));
        step("pop2", 0, 0, 0, 1, 0);
        check("drain.head3", out_data_o, mk(3, 375));
        step("pop3", 0, 0, 0, 1, 0);
        check("drain.cnt0", 32'(count_o), 32'd0);
        step("pop_empty", 0, 0, 0, 1, 0);
        check("underflow.cnt", 32'(count_o), 32'd0);

        // Overflow: nine pushes into an eight-deep FIFO.
        for (int i = 0; i < 9; i++) step("ovf_push", 0, 1, mk(4 + i, 100 + i), 0, 0);
        check("ovf.count", 32'(count_o), 32'd8);
        check("ovf.flag",  32'(ovf_o),   32'd1);
        check("ovf.full",  32'(full_o),  32'd1);
        step("ovf_clr", 0, 0, 0, 0, 1);
        check("clr.ovf",   32'(ovf_o),    32'd0);
        check("clr.count", 32'(count_o),  32'd8);
        check("clr.head",  out_data_o,    mk(4, 100));

        // Full with simultaneous push and pop.
        step("full_pp", 0, 1, mk(13, 999), 1, 0);
        check("pp.count", 32'(count_o), 32'd8);
        check("pp.ovf",   32'(ovf_o),   32'd0);
        check("pp.head",  out_data_o,   mk(5, 101));
        for (int i = 0; i < 8; i++) step("drain_all", 0, 0, 0, 1, 0);
        step("one_push", 0, 1, mk(14, 7), 0, 0);
        step("pp_at_one", 0, 1, mk(15, 8), 1, 0);
        check("pp1.count", 32'(count_o), 32'd1);
        check("pp1.head",  out_data_o,   mk(15, 8));

        // Randomized traffic against the model.
        seq_no = 16;
        for (int i = 0; i < 400; i++) begin
            bit v, rdy, c, r;
            v   = ($urandom_range(0, 9) < 6);
            rdy = ($urandom_range(0, 1) == 1);
            c   = ($urandom_range(0, 31) == 0);
            r   = ($urandom_range(0, 149) == 0);
            if (v && $urandom_range(0, 15) == 0) seq_no = seq_no + 2;
            step("rand", r, v, mk(seq_no, $urandom), rdy, c);
            if (v) seq_no = (seq_no + 1) % 256;
        end

        // Sequence checker with wrap and a gap.
        step("seq_rst", 1, 0, 0, 0, 0);
        step("seq254", 0, 1, mk(254, 1), 1, 0);
        step("seq255", 0, 1, mk(255, 2), 1, 0);
        step("seq0",   0, 1, mk(0, 3),   1, 0);
        check("seq.wrap_ok", 32'(seq_err_o), 32'd0);
        step("seq2",   0, 1, mk(2, 4),   1, 0);
        check("seq.gap", 32'(seq_err_o), 32'(SEQ_EN));
        step("seq_clr", 0, 0, 0, 1, 1);
        check("seq.clr", 32'(seq_err_o), 32'd0);

        // Reset in the middle of operation.
        step("mid_rst0", 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("mid_push", 0, 1, mk(50 + i, i), 0, 0);
        check("mid.count5", 32'(count_o), 32'd5);
        step("mid_rst", 1, 1, mk(60, 0), 1, 1);
        check("mid.empty", 32'(empty_o), 32'd1);
        step("mid_new", 0, 1, mk(7, 42), 0, 0);
        check("mid.head",  out_data_o,   mk(7, 42));
        check("mid.count", 32'(count_o), 32'd1);
        step("mid_pop", 0, 0, 0, 1, 0);
        check("mid.alone", 32'(empty_o), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
